alu_seq_mul: RTL
================

# alu_seq_mul

Sequential multiplier controller that sits directly upstream of the combinational `ALU` and computes `a * b` by repeated addition. It drives the ALU operand and command inputs itself, one `ADD` (cmd 0) per clock, and accumulates the ALU result into a registered product. The block replaces the bench-level repeated-add function with synthesizable hardware, using a start/done handshake towards the requester.

## Interface
Parameters:
- `N`, default 8: operand, accumulator and product width; must match the ALU's `N`.
- `M`, default 4: multiplier (`b`) width; it bounds the iteration count to at most 2^M−1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request; sampled only in `IDLE`.
- `a`, input, N: multiplicand; latched on an accepted `start`.
- `b`, input, M: multiplier (iteration count); latched on an accepted `start`.
- `busy`, output, 1: high while in `ADD`.
- `done`, output, 1: one-cycle pulse; `product` and `ovf` are valid from this cycle.
- `product`, output, N: accumulated result, truncated to N bits.
- `ovf`, output, 1: sticky; set if any add iteration raised the ALU `over` flag.
- `alu_op1`, output, N: drives ALU `op1`.
- `alu_op2`, output, N: drives ALU `op2`.
- `alu_cmd`, output, 4: drives ALU `cmd`.
- `alu_out`, input, N: from ALU `out`.
- `alu_over`, input, 1: from ALU `over`.

## Operation
State machine with three states: `IDLE`, `ADD`, `DONE`.

- **`IDLE`**
  - On `start=1`, latch `a_reg<=a` and `cnt<=b`, and clear `acc<=0` and `ovf<=0`.
  - Next state is `ADD` if `b!=0`, otherwise `DONE`.
- **`ADD`**
  - Combinational drive: `alu_op1=acc`, `alu_op2=a_reg`, `alu_cmd=4'd0`.
  - Each edge: `acc<=alu_out`, `ovf<=ovf|alu_over`, `cnt<=cnt-1`.
  - When `cnt==1`, next state is `DONE`; otherwise stay in `ADD`.
- **`DONE`**
  - `done=1` (Moore output).
  - Next state is `IDLE` unconditionally.
- **Outside `ADD`**: `alu_op1=0`, `alu_op2=0`, `alu_cmd=4'd0`, so the ALU sees a benign add of zeros.
- **`start` outside `IDLE`**: ignored, with no effect on `a_reg`, `cnt` or `acc`.
- **`product`**: equals `acc`. It holds its value through `IDLE` until the next accepted `start` clears it.
- **Width rule**: the result is `(a*b) mod 2^N`. `ovf` reflects the ALU's unsigned carry detection and is never recomputed locally.
- **Reset (any state, including mid-`ADD`)**:
  - State returns to `IDLE`.
  - `acc`, `cnt`, `a_reg` and `ovf` are cleared.
  - `busy=0`, `done=0`, `product=0`, ALU drive is 0 and cmd is 0.
  - No `done` is produced for an interrupted operation.

## Timing
- `start` accepted at edge k:
  - `busy` is high from edge k to edge k+b.
  - `done` is high for exactly the one cycle between edges k+b and k+b+1.
  - Latency from start to `done` is b+1 edges.
- `b=0`: no `ADD` cycles; `done` is high between edges k and k+1, with `product=0` and `ovf=0`.
- Back-to-back operation: the earliest next accepted `start` is at edge k+b+2, because the block passes through `IDLE` first. Sustained throughput is one operation per b+2 cycles.
- ALU path: `acc` and `a_reg` feed the ALU, and `alu_out` returns to `acc` within one cycle. This is a single combinational loop through the ALU per clock, with no pipeline register.

## Structure
- Shared package `alu_pkg` holds:
  - ALU command constants: `CMD_ADD=4'd0`, `CMD_SUB=1`, `CMD_SHL=2`, `CMD_SHR=3`, `CMD_EQ=4`, `CMD_GT=5`, `CMD_LT=6`.
  - The state encoding: `IDLE=2'd0`, `ADD=2'd1`, `DONE=2'd2`.
- No sub-module inside the block. The ALU is instantiated beside it by the enclosing level, and the bench instantiates both blocks.

## Test plan
- **Basic multiply**: `a=8`, `b=3`, pulse `start` → 3 `busy` cycles, then `done` one cycle later with `product=24`, `ovf=0`; ALU sees `op1` sequence 0, 8, 16 with `op2=8`.
- **Overflow**: `a=100`, `b=3` → `product=44` (300 mod 256), `ovf=1` set on the 3rd add and held through `IDLE`.
- **Zero multiplier**: `a=200`, `b=0` → `done` in the cycle after `start`, `product=0`, `ovf=0`, `busy` never high.
- **Maximum count and start blocking**: `a=255`, `b=15` → `product=241` (3825 mod 256), `ovf=1`, `done` at edge k+16. A second `start` with `a=1`, `b=1` during `busy` is ignored and the result is unchanged.
- **Mid-operation reset**: `a=5`, `b=10`, assert `rst` after 4 adds → immediately `busy=0`, `product=0`, no `done`. A fresh `a=5`, `b=2` then gives `product=10`.
- **Back-to-back**: `a=3`, `b=1`, then `start` held high continuously → results 3 repeatedly, with `done` every 3 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the combinational ALU and the sequential multiplier:
// ALU command codes and the multiplier state encoding.
package alu_pkg;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_SHL = 4'd2;
  localparam logic [3:0] CMD_SHR = 4'd3;
  localparam logic [3:0] CMD_EQ  = 4'd4;
  localparam logic [3:0] CMD_GT  = 4'd5;
  localparam logic [3:0] CMD_LT  = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU. over is the unsigned carry/borrow or shifted-out bit;
// the compare commands return a 0/1 result and never set over.
module alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  input  logic [3:0]   cmd,
  output logic [N-1:0] out,
  output logic         over
);

  logic [N:0] sum_s;
  logic [N:0] diff_s;

  assign sum_s  = {1'b0, op1} + {1'b0, op2};
  assign diff_s = {1'b0, op1} - {1'b0, op2};

  // Command decode
  always_comb begin
    out  = '0;
    over = 1'b0;
    case (cmd)
      CMD_ADD: begin
        out  = sum_s[N-1:0];
        over = sum_s[N];
      end
      CMD_SUB: begin
        out  = diff_s[N-1:0];
        over = diff_s[N];
      end
      CMD_SHL: begin
        out  = op1 << 1;
        over = op1[N-1];
      end
      CMD_SHR: begin
        out  = op1 >> 1;
        over = op1[0];
      end
      CMD_EQ:  out = {{(N-1){1'b0}}, (op1 == op2)};
      CMD_GT:  out = {{(N-1){1'b0}}, (op1 > op2)};
      CMD_LT:  out = {{(N-1){1'b0}}, (op1 < op2)};
      default: begin
        out  = '0;
        over = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_mul.sv
// Sequential multiplier: computes a*b by issuing b ADD commands to an external
// ALU and accumulating its result; start/done handshake towards the requester.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product,
  output logic         ovf,
  output logic [N-1:0] alu_op1,
  output logic [N-1:0] alu_op2,
  output logic [3:0]   alu_cmd,
  input  logic [N-1:0] alu_out,
  input  logic         alu_over
);

  mul_state_e  state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [M-1:0] cnt_q, cnt_d;
  logic [N-1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic and ALU drive; ALU sees a zero add outside ADD
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    alu_op1 = '0;
    alu_op2 = '0;
    alu_cmd = CMD_ADD;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          cnt_d   = b;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (b != '0) ? ADD : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        alu_op1 = acc_q;
        alu_op2 = a_q;
        acc_d   = alu_out;
        ovf_d   = ovf_q | alu_over;
        cnt_d   = cnt_q - {{(M-1){1'b0}}, 1'b1};
        if (cnt_q == {{(M-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == ADD);
  assign done    = (state_q == DONE);
  assign product = acc_q;
  assign ovf     = ovf_q;

endmodule
